// File: rtl/s344_scan_ctrl_if.sv
`default_nettype none
// s344_scan_ctrl_if: pattern stream handshake between the lab harness and the scan sequencer.
// Rev 1.0
interface s344_scan_ctrl_if #(
  parameter int CHAIN_LEN = 15,
  parameter int PI_W      = 9,
  parameter int PO_W      = 11
);
  logic                 pat_valid;
  logic                 pat_ready;
  logic [CHAIN_LEN-1:0] pat_chain;
  logic [PI_W-1:0]      pat_pi;
  logic [PO_W-1:0]      exp_po;
  logic [CHAIN_LEN-1:0] exp_chain;
  logic                 pat_last;

  modport master (
    output pat_valid, pat_chain, pat_pi, exp_po, exp_chain, pat_last,
    input  pat_ready
  );

  modport slave (
    input  pat_valid, pat_chain, pat_pi, exp_po, exp_chain, pat_last,
    output pat_ready
  );
endinterface
`default_nettype wire

// File: rtl/s344_scan_ctrl.sv
`default_nettype none
// s344_scan_ctrl: load/capture/unload sequencer for the s344 mux-scan chain with response checking.
// Rev 1.0
module s344_scan_ctrl #(
  parameter int CHAIN_LEN = 15,
  parameter int PI_W      = 9,
  parameter int PO_W      = 11
) (
  input  wire logic            CK,
  input  wire logic            RN,
  input  wire logic            start,
  s344_scan_ctrl_if.slave      pat,
  output logic                 scan_se,
  output logic                 scan_si,
  input  wire logic            scan_so,
  output logic [PI_W-1:0]      dut_pi,
  input  wire logic [PO_W-1:0] dut_po,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic                 underrun,
  output logic [7:0]           fail_cnt,
  output logic [7:0]           pat_cnt
);
  localparam int CW = $clog2(CHAIN_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_UNLOAD  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_bit;
  logic [CHAIN_LEN-1:0] r_chain;
  logic [CHAIN_LEN-1:0] r_exp_chain;
  logic [CHAIN_LEN-1:0] r_pend_exp;
  logic [PI_W-1:0]      r_pi;
  logic [PI_W-1:0]      r_dut_pi;
  logic [PO_W-1:0]      r_exp_po;
  logic                 r_last;
  logic                 r_pend_valid;
  logic                 r_pend_miss;
  logic                 r_scan_se;
  logic                 r_scan_si;
  logic                 r_pat_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_fail;
  logic                 r_underrun;
  logic [7:0]           r_fail_cnt;
  logic [7:0]           r_pat_cnt;

  logic w_shifting;
  logic w_last_bit;
  logic w_xfer;
  logic w_bit_miss;
  logic w_po_miss;

  assign w_shifting = (r_state == S_SHIFT) || (r_state == S_UNLOAD);
  assign w_last_bit = (r_bit == CW'(CHAIN_LEN - 1));
  assign w_xfer     = pat.pat_valid && r_pat_ready;
  assign w_bit_miss = scan_so ^ r_pend_exp[CHAIN_LEN-1];
  assign w_po_miss  = (dut_po != r_exp_po);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state      <= S_IDLE;
      r_bit        <= '0;
      r_chain      <= '0;
      r_exp_chain  <= '0;
      r_pend_exp   <= '0;
      r_pi         <= '0;
      r_dut_pi     <= '0;
      r_exp_po     <= '0;
      r_last       <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_miss  <= 1'b0;
      r_scan_se    <= 1'b0;
      r_scan_si    <= 1'b0;
      r_pat_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_underrun   <= 1'b0;
      r_fail_cnt   <= '0;
      r_pat_cnt    <= '0;
    end else begin
      r_done <= 1'b0;

      // Every shift edge moves the load one bit and checks the previous response bit leaving the chain.
      if (w_shifting) begin
        r_bit     <= r_bit + CW'(1);
        r_scan_si <= r_chain[CHAIN_LEN-1];
        r_chain   <= {r_chain[CHAIN_LEN-2:0], 1'b0};
        if (r_pend_valid) begin
          r_pend_exp  <= {r_pend_exp[CHAIN_LEN-2:0], 1'b0};
          r_pend_miss <= r_pend_miss | w_bit_miss;
          if (w_last_bit) begin
            r_pend_valid <= 1'b0;
            if (r_pend_miss || w_bit_miss) begin
              r_fail <= 1'b1;
              if (r_fail_cnt != 8'hFF) r_fail_cnt <= r_fail_cnt + 8'd1;
            end
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_WAIT;
            r_busy      <= 1'b1;
            r_pat_ready <= 1'b1;
            r_fail      <= 1'b0;
            r_underrun  <= 1'b0;
            r_fail_cnt  <= '0;
            r_pat_cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (w_xfer) begin
            r_pi        <= pat.pat_pi;
            r_exp_po    <= pat.exp_po;
            r_exp_chain <= pat.exp_chain;
            r_last      <= pat.pat_last;
            r_scan_si   <= pat.pat_chain[CHAIN_LEN-1];
            r_chain     <= {pat.pat_chain[CHAIN_LEN-2:0], 1'b0};
            r_bit       <= '0;
            r_scan_se   <= 1'b1;
            r_pat_ready <= 1'b0;
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_last_bit) begin
            r_scan_se   <= 1'b0;
            r_scan_si   <= 1'b0;
            r_dut_pi    <= r_pi;
            r_pat_ready <= !r_last;
            r_state     <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_dut_pi     <= '0;
          r_pat_ready  <= 1'b0;
          r_scan_se    <= 1'b1;
          r_bit        <= '0;
          r_pend_exp   <= r_exp_chain;
          r_pend_miss  <= w_po_miss;
          r_pend_valid <= 1'b1;
          if (r_pat_cnt != 8'hFF) r_pat_cnt <= r_pat_cnt + 8'd1;
          if (w_xfer) begin
            r_pi        <= pat.pat_pi;
            r_exp_po    <= pat.exp_po;
            r_exp_chain <= pat.exp_chain;
            r_last      <= pat.pat_last;
            r_scan_si   <= pat.pat_chain[CHAIN_LEN-1];
            r_chain     <= {pat.pat_chain[CHAIN_LEN-2:0], 1'b0};
            r_state     <= S_SHIFT;
          end else begin
            // Unload the final response with zeros; a missing non-last pattern is an underrun.
            r_scan_si  <= 1'b0;
            r_chain    <= '0;
            r_underrun <= r_underrun | !r_last;
            r_state    <= S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          if (w_last_bit) begin
            r_scan_se <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pat.pat_ready = r_pat_ready;
  assign scan_se       = r_scan_se;
  assign scan_si       = r_scan_si;
  assign dut_pi        = r_dut_pi;
  assign busy          = r_busy;
  assign done          = r_done;
  assign fail          = r_fail;
  assign underrun      = r_underrun;
  assign fail_cnt      = r_fail_cnt;
  assign pat_cnt       = r_pat_cnt;
endmodule
`default_nettype wire

// File: tb/tb_s344_scan_ctrl.sv
`default_nettype none
// tb_s344_scan_ctrl: session table plus scoreboarded scan stream against an inverting mux-scan chain model.
// Rev 1.0
module tb_s344_scan_ctrl;
  localparam int CL = 15;

  logic        CK = 1'b0;
  logic        RN = 1'b0;
  logic        start = 1'b0;
  logic        scan_se, scan_si, scan_so;
  logic [8:0]  dut_pi;
  logic [10:0] dut_po;
  logic        busy, done, fail, underrun;
  logic [7:0]  fail_cnt, pat_cnt;

  s344_scan_ctrl_if #(.CHAIN_LEN(CL), .PI_W(9), .PO_W(11)) pif ();

  s344_scan_ctrl #(.CHAIN_LEN(CL), .PI_W(9), .PO_W(11)) dut (
    .CK(CK), .RN(RN), .start(start), .pat(pif),
    .scan_se(scan_se), .scan_si(scan_si), .scan_so(scan_so),
    .dut_pi(dut_pi), .dut_po(dut_po),
    .busy(busy), .done(done), .fail(fail), .underrun(underrun),
    .fail_cnt(fail_cnt), .pat_cnt(pat_cnt)
  );

  always #5 CK = ~CK;

  // Chain model: mux-scan register whose functional capture inverts every flop.
  logic [CL-1:0] m_q = '0;
  always @(posedge CK) m_q <= scan_se ? {m_q[CL-2:0], scan_si} : ~m_q;
  assign scan_so = m_q[CL-1];
  assign dut_po  = {2'b00, dut_pi};

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  typedef struct {
    int          npat;
    logic [14:0] chain_base;
    logic [8:0]  pi_base;
    logic [3:0]  po_err;
    logic [3:0]  ch_err;
    bit          drop;
    bit          poke;
    logic [7:0]  e_pat;
    logic [7:0]  e_fcnt;
    bit          e_fail;
    bit          e_under;
  } sess_t;

  sess_t tbl[5];
  int    n_tot = 0;
  int    n_bad = 0;
  int    se_cnt = 0;
  bit    prev_se = 1'b0;
  logic  sb_si[$];
  logic [8:0] sb_pi[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic feed(input sess_t s, input bit mark_last, output int t_first);
    int i = 0;
    int budget = 400;
    int t_prev = 0;
    logic [14:0] ch;
    logic [8:0]  pi;
    t_first = 0;
    while (i < s.npat && budget > 0) begin
      @(negedge CK);
      budget--;
      ch = s.chain_base + 15'(i) * 15'h0B3D;
      pi = s.pi_base + 9'(i) * 9'h033;
      pif.pat_valid = 1'b1;
      pif.pat_chain = ch;
      pif.pat_pi    = pi;
      pif.exp_po    = s.po_err[i] ? 11'h001 : {2'b00, pi};
      pif.exp_chain = ~ch ^ (s.ch_err[i] ? (15'd1 << i) : 15'd0);
      pif.pat_last  = mark_last && (i == s.npat - 1);
      start = s.poke && (i == 3);
      if (pif.pat_ready) begin
        for (int b = CL - 1; b >= 0; b--) sb_si.push_back(ch[b]);
        sb_pi.push_back(pi);
        if (i == 0) t_first = cyc + 1;
        else check("xfer_gap", 32'(cyc + 1 - t_prev), 32'd16);
        t_prev = cyc + 1;
        i++;
      end
    end
    if (i < s.npat) check("feed_timeout", 32'(i), 32'(s.npat));
    @(negedge CK);
    pif.pat_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_session(input sess_t s, input string tag);
    int t1;
    int se0;
    int budget;
    @(negedge CK);
    start = 1'b1;
    @(negedge CK);
    start = 1'b0;
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    check({tag, "_ready_wait"}, 32'(pif.pat_ready), 32'd1);
    check({tag, "_clr_fail"}, 32'(fail), 32'd0);
    check({tag, "_clr_cnt"}, {16'd0, fail_cnt, pat_cnt}, 32'd0);
    se0 = se_cnt;
    feed(s, !s.drop, t1);
    for (int b = 0; b < CL; b++) sb_si.push_back(1'b0);
    budget = 300;
    while (done !== 1'b1 && budget > 0) begin
      @(negedge CK);
      budget--;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_done_time"}, 32'(cyc - t1), 32'(s.npat * 16 + 15));
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_pat_cnt"}, 32'(pat_cnt), 32'(s.e_pat));
    check({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(s.e_fcnt));
    check({tag, "_fail"}, 32'(fail), 32'(s.e_fail));
    check({tag, "_underrun"}, 32'(underrun), 32'(s.e_under));
    check({tag, "_se_cycles"}, 32'(se_cnt - se0), 32'(CL * (s.npat + 1)));
    @(negedge CK);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_sb_empty"}, 32'(sb_si.size() + sb_pi.size()), 32'd0);
  endtask

  initial begin
    int t1;
    int t2;
    int budget;
    int n_done;
    sess_t rs;

    //          npat base      pi      po_err   ch_err   drop poke pat fcnt fail under
    tbl[0] = '{1, 15'h1234, 9'h0A5, 4'b0000, 4'b0000, 0, 0, 8'd1, 8'd0, 0, 0};
    tbl[1] = '{1, 15'h1234, 9'h0A5, 4'b0000, 4'b0001, 0, 0, 8'd1, 8'd1, 1, 0};
    tbl[2] = '{4, 15'h0F0F, 9'h0A5, 4'b0100, 4'b0000, 0, 1, 8'd4, 8'd1, 1, 0};
    tbl[3] = '{2, 15'h3A5C, 9'h133, 4'b0000, 4'b0000, 1, 0, 8'd2, 8'd0, 0, 1};
    tbl[4] = '{3, 15'h5555, 9'h1FF, 4'b0001, 4'b0101, 0, 0, 8'd3, 8'd2, 1, 0};

    pif.pat_valid = 1'b0;
    pif.pat_chain = '0;
    pif.pat_pi    = '0;
    pif.exp_po    = '0;
    pif.exp_chain = '0;
    pif.pat_last  = 1'b0;

    fork
      forever begin
        @(negedge CK);
        if (scan_se) begin
          se_cnt++;
          if (sb_si.size() == 0) check("sb_si_underflow", 32'd1, 32'd0);
          else check("scan_si", 32'(scan_si), 32'(sb_si.pop_front()));
        end
        if (prev_se && !scan_se && busy) begin
          if (sb_pi.size() == 0) check("sb_pi_underflow", 32'd1, 32'd0);
          else check("capture_pi", 32'(dut_pi), 32'(sb_pi.pop_front()));
        end
        prev_se = scan_se;
      end
    join_none

    repeat (3) @(negedge CK);
    check("rst_outputs", {scan_se, pif.pat_ready, busy, done, fail, underrun, 26'd0},
          32'd0);
    check("rst_counters", {16'd0, fail_cnt, pat_cnt}, 32'd0);
    RN = 1'b1;

    for (int k = 0; k < 5; k++) run_session(tbl[k], $sformatf("s%0d", k));

    // Reset during the 8th shift cycle of the second pattern abandons the session.
    rs = '{3, 15'h2468, 9'h055, 4'b0000, 4'b0000, 1, 0, 8'd0, 8'd0, 0, 0};
    rs.npat = 2;
    @(negedge CK);
    start = 1'b1;
    @(negedge CK);
    start = 1'b0;
    feed(rs, 1'b0, t1);
    t2 = t1 + 16;
    budget = 100;
    while (cyc < t2 + 7 && budget > 0) begin
      @(posedge CK);
      #1;
      budget--;
    end
    check("pre_rst_shift", 32'(scan_se), 32'd1);
    check("pre_rst_pat_cnt", 32'(pat_cnt), 32'd1);
    #1;
    RN = 1'b0;
    #1;
    check("async_rst_se", 32'(scan_se), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_pat_cnt", 32'(pat_cnt), 32'd0);
    check("async_rst_ready", 32'(pif.pat_ready), 32'd0);
    sb_si.delete();
    sb_pi.delete();
    repeat (2) @(negedge CK);
    RN = 1'b1;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CK);
      if (done) n_done++;
    end
    check("no_done_after_rst", 32'(n_done), 32'd0);
    run_session(tbl[0], "post_rst");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
